// File: rtl/up_sample.sv
// Nearest-neighbour 2x upsampler for channel-interleaved pixel lines.
// One line is buffered, then replayed as two lines of doubled pixels.
module up_sample #(
   parameter int DATA_WIDTH  = 8,
   parameter int CHANNEL_NUM = 3,
   parameter int STRING_LEN  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sop_i,
   input  logic                         eop_i,
   input  logic                         sof_i,
   input  logic                         eof_i,
   input  logic                         valid_i,
   input  logic signed [DATA_WIDTH-1:0] data_i,
   output logic                         ready_o,
   output logic signed [DATA_WIDTH-1:0] data_o,
   output logic                         data_valid_o,
   output logic                         sop_o,
   output logic                         eop_o,
   output logic                         sof_o,
   output logic                         eof_o,
   output logic                         err_o
);

   localparam int N  = CHANNEL_NUM * STRING_LEN;
   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
   localparam int PW = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;

   localparam logic [1:0] LOAD  = 2'd0;
   localparam logic [1:0] OUT_A = 2'd1;
   localparam logic [1:0] OUT_B = 2'd2;

   localparam logic [AW-1:0] LAST_WR  = AW'(N - 1);
   localparam logic [AW-1:0] C_STEP   = AW'(CHANNEL_NUM);
   localparam logic [CW-1:0] LAST_CH  = CW'(CHANNEL_NUM - 1);
   localparam logic [PW-1:0] LAST_PIX = PW'(STRING_LEN - 1);

   logic [1:0]    state;
   logic [AW-1:0] wr_cnt;
   logic [CW-1:0] ch;
   logic          rep;
   logic [PW-1:0] pix;
   logic [AW-1:0] base;
   logic          frame_start;
   logic          frame_end;

   logic signed [DATA_WIDTH-1:0] mem [N];

   logic          accept;
   logic          wr_last;
   logic          rd_on;
   logic          rd_first;
   logic          rd_last;

   // read pipeline: s1 = issued address, s2 = RAM output, then output regs
   logic          s1_v, s1_sop, s1_eop, s1_sof, s1_eof;
   logic [AW-1:0] s1_addr;
   logic          s2_v, s2_sop, s2_eop, s2_sof, s2_eof;
   logic signed [DATA_WIDTH-1:0] s2_data;

   assign accept   = valid_i & ready_o;
   assign wr_last  = (wr_cnt == LAST_WR);
   assign rd_on    = (state == OUT_A) | (state == OUT_B);
   assign rd_first = (ch == '0) & ~rep & (pix == '0);
   assign rd_last  = (ch == LAST_CH) & rep & (pix == LAST_PIX);

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_cnt] <= data_i;
      s2_data <= mem[s1_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= LOAD;
         wr_cnt      <= '0;
         ch          <= '0;
         rep         <= 1'b0;
         pix         <= '0;
         base        <= '0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         ready_o     <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         ready_o <= ((state == LOAD) & ~(accept & wr_last))
                  | ((state == OUT_B) & rd_last);
         if (valid_i & ~ready_o)
            err_o <= 1'b1;
         case (state)
            LOAD: begin
               if (accept) begin
                  if (wr_cnt == '0)
                     frame_start <= sof_i;
                  // eop must mark exactly the last word of the line
                  if (eop_i != wr_last)
                     err_o <= 1'b1;
                  if (wr_last) begin
                     frame_end <= eof_i;
                     wr_cnt    <= '0;
                     state     <= OUT_A;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            OUT_A, OUT_B: begin
               if (ch == LAST_CH) begin
                  ch  <= '0;
                  rep <= ~rep;
                  if (rep) begin
                     if (pix == LAST_PIX) begin
                        pix  <= '0;
                        base <= '0;
                     end else begin
                        pix  <= pix + 1'b1;
                        base <= base + C_STEP;
                     end
                  end
               end else begin
                  ch <= ch + 1'b1;
               end
               if (rd_last)
                  state <= (state == OUT_A) ? OUT_B : LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v    <= 1'b0;
         s1_addr <= '0;
         s1_sop  <= 1'b0;
         s1_eop  <= 1'b0;
         s1_sof  <= 1'b0;
         s1_eof  <= 1'b0;
         s2_v    <= 1'b0;
         s2_sop  <= 1'b0;
         s2_eop  <= 1'b0;
         s2_sof  <= 1'b0;
         s2_eof  <= 1'b0;
      end else begin
         s1_v    <= rd_on;
         s1_addr <= base + AW'(ch);
         s1_sop  <= rd_on & rd_first;
         s1_eop  <= rd_on & rd_last;
         s1_sof  <= (state == OUT_A) & rd_first & frame_start;
         s1_eof  <= (state == OUT_B) & rd_last & frame_end;
         s2_v    <= s1_v;
         s2_sop  <= s1_sop;
         s2_eop  <= s1_eop;
         s2_sof  <= s1_sof;
         s2_eof  <= s1_eof;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_o       <= '0;
         data_valid_o <= 1'b0;
         sop_o        <= 1'b0;
         eop_o        <= 1'b0;
         sof_o        <= 1'b0;
         eof_o        <= 1'b0;
      end else begin
         data_o       <= s2_v ? s2_data : '0;
         data_valid_o <= s2_v;
         sop_o        <= s2_sop;
         eop_o        <= s2_eop;
         sof_o        <= s2_sof;
         eof_o        <= s2_eof;
      end
   end

endmodule

// File: tb/tb_up_sample.sv
// Directed bench for up_sample with hand-derived expected output streams.
module tb_up_sample;

   localparam int N = 12;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sop_i = 1'b0, eop_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
   logic valid_i = 1'b0;
   logic signed [7:0] data_i = '0;
   logic ready_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o;
   logic signed [7:0] data_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic signed [7:0] vecs [2][N];
   logic signed [7:0] q_data [$];
   logic [3:0]        q_flag [$];
   int                q_cyc  [$];

   up_sample dut (
      .clk(clk), .reset(reset),
      .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
      .valid_i(valid_i), .data_i(data_i),
      .ready_o(ready_o), .data_o(data_o), .data_valid_o(data_valid_o),
      .sop_o(sop_o), .eop_o(eop_o), .sof_o(sof_o), .eof_o(eof_o),
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_valid_o === 1'b1) begin
         q_data.push_back(data_o);
         q_flag.push_back({sop_o, eop_o, sof_o, eof_o});
         q_cyc.push_back(cyc);
      end
   end

   task automatic clear_q();
      q_data.delete();
      q_flag.delete();
      q_cyc.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      clear_q();
   endtask

   task automatic send_line(input int l, input bit sof, input bit eof,
                            input int eop_at, output int acc_cyc);
      acc_cyc = 0;
      for (int i = 0; i < N; i++) begin
         int t = 0;
         while (ready_o !== 1'b1 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
         end
         if (t >= 400) begin
            checks++;
            failures++;
            $display("FAIL send_wait ready_o=%b required 1", ready_o);
         end
         valid_i = 1'b1;
         data_i  = vecs[l][i];
         sop_i   = (i == 0);
         eop_i   = (i == eop_at);
         sof_i   = sof && (i == 0);
         eof_i   = eof && (i == N - 1);
         @(posedge clk);
         #1;
         acc_cyc = cyc;
      end
      valid_i = 1'b0;
      sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
      data_i = '0;
   endtask

   task automatic wait_outs(input int n);
      int t = 0;
      while (q_data.size() < n && t < 1000) begin
         @(negedge clk);
         t++;
      end
      repeat (6) @(negedge clk);
      checks++;
      if (q_data.size() !== n)
         $display("FAIL out_count got=%0d required=%0d", q_data.size(), n);
      if (q_data.size() !== n) failures++;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ready_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, data_o} !== 15'd0) begin
         failures++;
         $display("FAIL reset_outs got=%b required 0",
                  {ready_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, data_o});
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b0) begin
         failures++;
         $display("FAIL ready_hold got=%b required 0", ready_o);
      end
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset got=%b required 1", ready_o);
      end
      @(posedge clk);
      #1;
      clear_q();
   endtask

   task automatic test_basic();
      int acc, rdy_cyc, t;
      logic signed [7:0] ev;
      logic [3:0] ef;
      for (int i = 0; i < N; i++) vecs[0][i] = 8'(i);
      clear_q();
      send_line(0, 1'b1, 1'b0, N - 1, acc);
      checks++;
      if (ready_o !== 1'b0) begin
         failures++;
         $display("FAIL ready_drop got=%b required 0", ready_o);
      end
      t = 0;
      while (ready_o !== 1'b1 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      rdy_cyc = cyc;
      checks++;
      if (rdy_cyc !== acc + 48) begin
         failures++;
         $display("FAIL ready_return got=%0d required=%0d", rdy_cyc - acc, 48);
      end
      wait_outs(48);
      if (q_data.size() == 48) begin
         checks++;
         if (q_cyc[0] !== acc + 3) begin
            failures++;
            $display("FAIL first_valid_lat got=%0d required=3", q_cyc[0] - acc);
         end
         checks++;
         if (q_cyc[47] !== q_cyc[0] + 47) begin
            failures++;
            $display("FAIL burst_contig got=%0d required=47", q_cyc[47] - q_cyc[0]);
         end
         for (int j = 0; j < 48; j++) begin
            int k;
            k  = j % 24;
            ev = vecs[0][(k / 6) * 3 + (k % 3)];
            ef = {k == 0, k == 23, j == 0, 1'b0};
            checks++;
            if (q_data[j] !== ev || q_flag[j] !== ef) begin
               failures++;
               $display("FAIL basic_word%0d got=%0d/%b required=%0d/%b",
                        j, q_data[j], q_flag[j], ev, ef);
            end
         end
      end
   endtask

   task automatic test_two_line_frame();
      int acc;
      logic signed [7:0] ev;
      logic [3:0] ef;
      for (int i = 0; i < N; i++) begin
         vecs[0][i] = 8'(50 + i);
         vecs[1][i] = 8'(20 + i);
      end
      clear_q();
      send_line(0, 1'b1, 1'b0, N - 1, acc);
      send_line(1, 1'b0, 1'b1, N - 1, acc);
      wait_outs(96);
      if (q_data.size() == 96) begin
         for (int j = 0; j < 96; j++) begin
            int l, k;
            l  = j / 48;
            k  = (j % 48) % 24;
            ev = vecs[l][(k / 6) * 3 + (k % 3)];
            ef = {k == 0, k == 23, j == 0, j == 95};
            checks++;
            if (q_data[j] !== ev || q_flag[j] !== ef) begin
               failures++;
               $display("FAIL frame_word%0d got=%0d/%b required=%0d/%b",
                        j, q_data[j], q_flag[j], ev, ef);
            end
         end
      end
   endtask

   task automatic test_signed();
      int acc;
      logic signed [7:0] ev;
      vecs[0][0] = 8'sh80;
      vecs[0][1] = 8'sh7f;
      vecs[0][2] = 8'shff;
      for (int i = 3; i < N; i++) vecs[0][i] = 8'(i * 7 - 40);
      clear_q();
      send_line(0, 1'b0, 1'b0, N - 1, acc);
      wait_outs(48);
      if (q_data.size() == 48) begin
         for (int j = 0; j < 48; j++) begin
            int k;
            k  = j % 24;
            ev = vecs[0][(k / 6) * 3 + (k % 3)];
            checks++;
            if (q_data[j] !== ev) begin
               failures++;
               $display("FAIL signed_word%0d got=%0d required=%0d", j, q_data[j], ev);
            end
         end
      end
   endtask

   task automatic test_err_ready();
      int acc;
      int seen;
      do_reset();
      checks++;
      if (err_o !== 1'b0) begin
         failures++;
         $display("FAIL err_clear got=%b required 0", err_o);
      end
      for (int i = 0; i < N; i++) vecs[0][i] = 8'(i + 1);
      send_line(0, 1'b0, 1'b0, N - 1, acc);
      valid_i = 1'b1;
      data_i  = 8'sd99;
      @(posedge clk);
      #1 valid_i = 1'b0;
      data_i = '0;
      checks++;
      if (err_o !== 1'b1) begin
         failures++;
         $display("FAIL err_not_ready got=%b required 1", err_o);
      end
      wait_outs(48);
      seen = 0;
      foreach (q_data[j]) if (q_data[j] == 8'sd99) seen++;
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL dropped_word got=%0d required=0", seen);
      end
   endtask

   task automatic test_err_eop();
      int acc;
      do_reset();
      for (int i = 0; i < N; i++) vecs[0][i] = 8'(i + 60);
      send_line(0, 1'b0, 1'b0, 5, acc);
      checks++;
      if (err_o !== 1'b1) begin
         failures++;
         $display("FAIL err_eop got=%b required 1", err_o);
      end
      wait_outs(48);
      if (q_data.size() == 48) begin
         checks++;
         if (q_data[47] !== 8'sd71 || q_data[6] !== 8'sd63) begin
            failures++;
            $display("FAIL eop_line_data got=%0d,%0d required=71,63", q_data[47], q_data[6]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int acc, t, sz;
      do_reset();
      for (int i = 0; i < N; i++) vecs[0][i] = 8'(i + 5);
      send_line(0, 1'b1, 1'b0, N - 1, acc);
      t = 0;
      while (q_data.size() < 11 && t < 200) begin
         @(negedge clk);
         t++;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({ready_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, data_o} !== 15'd0) begin
         failures++;
         $display("FAIL midreset_outs got=%b required 0",
                  {ready_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, data_o});
      end
      sz = q_data.size();
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      checks++;
      if (q_data.size() !== sz || ready_o !== 1'b1) begin
         failures++;
         $display("FAIL midreset_quiet got=%0d/%b required=%0d/1", q_data.size(), ready_o, sz);
      end
      for (int i = 0; i < N; i++) vecs[0][i] = 8'(i + 40);
      clear_q();
      send_line(0, 1'b0, 1'b0, N - 1, acc);
      wait_outs(48);
      if (q_data.size() == 48) begin
         checks++;
         if (q_data[0] !== 8'sd40 || q_data[24] !== 8'sd40 || q_flag[24] !== 4'b1000) begin
            failures++;
            $display("FAIL reload_line got=%0d,%0d,%b required=40,40,1000",
                     q_data[0], q_data[24], q_flag[24]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_two_line_frame();
      test_signed();
      test_err_ready();
      test_err_eop();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
